// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial adder sequencer.
// Contents:
//   state_e - sequencer state encoding (S_IDLE, S_ADD, S_FINISH)
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADD    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full adder, time-shared by the sequencer across all bit positions.
// Ports:
//   a, b   - operand bits
//   c_in   - carry in
//   c_out  - carry out
//   sum    - sum bit
module serial_add_ctrl_fulladder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic c_out,
    output logic sum
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full adder walks the LSB-first bit positions of two
// WIDTH-bit operands, one bit every TICKS_PER_BIT clocks, so the ripple is visible on LEDs.
// Ports:
//   clk      - system clock
//   rst      - synchronous reset, active-high
//   start    - request pulse, accepted only when idle
//   a_in     - operand A, sampled on the accepted start
//   b_in     - operand B, sampled on the accepted start
//   sum      - last completed result (modulo 2^WIDTH)
//   cout     - carry out of the MSB for the last completed result
//   busy     - high while an add is in progress
//   done     - one-cycle pulse once sum/cout hold the new result
//   bit_idx  - bit position currently being added
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned TICKS_PER_BIT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a_in,
    input  logic [WIDTH-1:0]           b_in,
    output logic [WIDTH-1:0]           sum,
    output logic                       cout,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] bit_idx
);

    localparam int unsigned TickW = $clog2(TICKS_PER_BIT + 1);
    localparam int unsigned IdxW  = $clog2(WIDTH + 1);

    state_e state_q, state_d;

    logic [TickW-1:0] tick_q, tick_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic             step;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH:0]   sum_ins;

    serial_add_ctrl_fulladder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c_in  (carry_q),
        .c_out (fa_cout),
        .sum   (fa_sum)
    );

    // A bit step happens on the last tick of each bit period.
    assign step     = (state_q == S_ADD) && (tick_q == TickW'(TICKS_PER_BIT - 1));
    assign last_bit = (idx_q == IdxW'(WIDTH - 1));
    // New sum bit enters at the MSB; upper WIDTH bits are the shifted result.
    assign sum_ins  = {fa_sum, sum_sh_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_ADD;
            S_ADD:    if (step && last_bit) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy    = (state_q == S_ADD);
        done    = done_q;
        sum     = sum_q;
        cout    = cout_q;
        bit_idx = idx_q;
    end

    // Datapath next-state
    always_comb begin
        tick_d   = tick_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        // done trails FINISH by one cycle so it lands after the state returns to idle
        done_d   = (state_q == S_FINISH);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = a_in;
                    b_sh_d   = b_in;
                    carry_d  = 1'b0;
                    tick_d   = '0;
                    idx_d    = '0;
                    sum_sh_d = '0;
                end
            end
            S_ADD: begin
                if (step) begin
                    sum_sh_d = sum_ins[WIDTH:1];
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    carry_d  = fa_cout;
                    tick_d   = '0;
                    idx_d    = idx_q + 1'b1;
                    if (last_bit) begin
                        sum_d  = sum_ins[WIDTH:1];
                        cout_d = fa_cout;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_FINISH: idx_d = '0;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
        end
    end

endmodule
